// File: rtl/alu_acc_seq.sv
// alu_acc_seq: accumulator ALU with valid/ready handshakes on both sides.
// Sixteen opcodes at WIDTH bits. DIV is a restoring divider that produces
// one quotient bit per cycle. All other ops, and DIV by zero, complete in
// one cycle. Every completed op writes its result to both acc and res.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   opcode/A/B valid          in_ready   high only while IDLE
//   opcode     operation select          A, B       unsigned operands
//   acc_clr    accumulator clear, honoured only in IDLE
//   out_valid  res/flags valid; held until out_ready
//   out_ready  consumer takes the result
//   res        result (copy of the new acc)
//   carry      carry/borrow/overflow     zero       res == 0
//   err        divide by zero
module alu_acc_seq #(
   parameter int unsigned WIDTH   = 8,
   parameter bit          ACC_SAT = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       opcode,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res,
   output logic             carry,
   output logic             zero,
   output logic             err
);

   localparam int unsigned SHW = $clog2(WIDTH);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_MUL  = 4'd2;
   localparam logic [3:0] OP_DIV  = 4'd3;
   localparam logic [3:0] OP_ADDA = 4'd4;
   localparam logic [3:0] OP_MULA = 4'd5;
   localparam logic [3:0] OP_MAC  = 4'd6;
   localparam logic [3:0] OP_ROL  = 4'd7;
   localparam logic [3:0] OP_ROR  = 4'd8;
   localparam logic [3:0] OP_AND  = 4'd9;
   localparam logic [3:0] OP_OR   = 4'd10;
   localparam logic [3:0] OP_XOR  = 4'd11;
   localparam logic [3:0] OP_NAND = 4'd12;
   localparam logic [3:0] OP_ETH  = 4'd13;
   localparam logic [3:0] OP_GTH  = 4'd14;
   localparam logic [3:0] OP_LTH  = 4'd15;

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_HOLD} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, res_q;
   logic             carry_q, zero_q, err_q;
   logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
   logic [SHW-1:0]   cnt_q;

   logic             accept;
   logic             div_start;
   logic             div_last;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   assign accept    = in_valid && (state_q == S_IDLE);
   assign div_start = (opcode == OP_DIV) && (B != '0);
   assign div_last  = (cnt_q == SHW'(WIDTH - 1));

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (accept)    state_d = div_start ? S_DIV : S_HOLD;
         S_DIV:  if (div_last)  state_d = S_HOLD;
         S_HOLD: if (out_ready) state_d = S_IDLE;
         default:               state_d = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      in_ready  = (state_q == S_IDLE);
      out_valid = (state_q == S_HOLD);
   end

   assign res   = res_q;
   assign carry = carry_q;
   assign zero  = zero_q;
   assign err   = err_q;

   // ---------------- single-cycle ALU ----------------
   logic [WIDTH-1:0]   acc_op;
   logic [WIDTH:0]     sum_ab, sum_acc;
   logic [2*WIDTH-1:0] mul_ab, mul_acc;
   logic [2*WIDTH:0]   mac_sum;
   logic [SHW-1:0]     sh, idx_l, idx_r;
   logic [WIDTH-1:0]   rol_v, ror_v;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_c, alu_e;

   always_comb begin
      // acc_clr coinciding with an accept makes the op see a zero accumulator
      acc_op  = acc_clr ? '0 : acc_q;
      sum_ab  = {1'b0, A} + {1'b0, B};
      sum_acc = {1'b0, acc_op} + {1'b0, A};
      mul_ab  = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
      mul_acc = {{WIDTH{1'b0}}, acc_op} * {{WIDTH{1'b0}}, A};
      mac_sum = {1'b0, {WIDTH{1'b0}}, acc_op} + {1'b0, mul_ab};
      sh      = B[SHW-1:0];
      idx_l   = '0;
      idx_r   = '0;
      rol_v   = '0;
      ror_v   = '0;
      // Rotations index A modulo WIDTH; the SHW-bit index wraps naturally.
      for (int unsigned i = 0; i < WIDTH; i++) begin
         idx_l    = SHW'(i) - sh;
         idx_r    = SHW'(i) + sh;
         rol_v[i] = A[idx_l];
         ror_v[i] = A[idx_r];
      end

      alu_res = '0;
      alu_c   = 1'b0;
      alu_e   = 1'b0;
      unique case (opcode)
         OP_ADD:  begin alu_res = sum_ab[WIDTH-1:0];  alu_c = sum_ab[WIDTH]; end
         OP_SUB:  begin alu_res = A - B;              alu_c = (A < B); end
         OP_MUL:  begin alu_res = mul_ab[WIDTH-1:0];  alu_c = |mul_ab[2*WIDTH-1:WIDTH]; end
         // Only the divide-by-zero case completes through this path.
         OP_DIV:  begin alu_res = '1;                 alu_e = 1'b1; end
         OP_ADDA: begin alu_res = sum_acc[WIDTH-1:0]; alu_c = sum_acc[WIDTH]; end
         OP_MULA: begin alu_res = mul_acc[WIDTH-1:0]; alu_c = |mul_acc[2*WIDTH-1:WIDTH]; end
         OP_MAC:  begin alu_res = mac_sum[WIDTH-1:0]; alu_c = |mac_sum[2*WIDTH:WIDTH]; end
         OP_ROL:  alu_res = rol_v;
         OP_ROR:  alu_res = ror_v;
         OP_AND:  alu_res = A & B;
         OP_OR:   alu_res = A | B;
         OP_XOR:  alu_res = A ^ B;
         OP_NAND: alu_res = ~(A & B);
         OP_ETH:  alu_res = {{(WIDTH-1){1'b0}}, (A == B)};
         OP_GTH:  alu_res = {{(WIDTH-1){1'b0}}, (A > B)};
         OP_LTH:  alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
         default: alu_res = '0;
      endcase
      if (ACC_SAT && alu_c && ((opcode == OP_ADDA) || (opcode == OP_MAC)))
         alu_res = '1;
   end

   // ---------------- restoring divider step ----------------
   logic [WIDTH:0]   rem_sh, trial;
   logic [WIDTH-1:0] rem_d, quo_d;

   always_comb begin
      rem_sh = {rem_q, quo_q[WIDTH-1]};
      trial  = rem_sh - {1'b0, dvs_q};
      // rem_q < dvs_q always holds, so trial[WIDTH] is a clean sign bit
      if (!trial[WIDTH]) begin
         rem_d = trial[WIDTH-1:0];
         quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
         rem_d = rem_sh[WIDTH-1:0];
         quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q   <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
         err_q   <= 1'b0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         cnt_q   <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (accept) begin
                  if (div_start) begin
                     rem_q <= '0;
                     quo_q <= A;
                     dvs_q <= B;
                     cnt_q <= '0;
                  end else begin
                     acc_q   <= alu_res;
                     res_q   <= alu_res;
                     carry_q <= alu_c;
                     zero_q  <= (alu_res == '0);
                     err_q   <= alu_e;
                  end
               end else if (acc_clr) begin
                  acc_q <= '0;
               end
            end
            S_DIV: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               cnt_q <= cnt_q + 1'b1;
               if (div_last) begin
                  acc_q   <= quo_d;
                  res_q   <= quo_d;
                  carry_q <= 1'b0;
                  zero_q  <= (quo_d == '0);
                  err_q   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_acc_seq.sv
// Directed bench for alu_acc_seq at WIDTH=8: one wrapping instance and one
// saturating instance driven by the same stimulus.
module tb_alu_acc_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       acc_clr = 1'b0;
   logic       out_ready = 1'b0;
   logic [3:0] opcode = 4'd0;
   logic [7:0] A = 8'd0;
   logic [7:0] B = 8'd0;

   logic       in_ready, out_valid, carry, zero, err;
   logic [7:0] res;
   logic       s_in_ready, s_out_valid, s_carry, s_zero, s_err;
   logic [7:0] s_res;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_acc_seq #(.WIDTH(8), .ACC_SAT(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .A(A), .B(B), .acc_clr(acc_clr),
      .out_valid(out_valid), .out_ready(out_ready), .res(res),
      .carry(carry), .zero(zero), .err(err)
   );

   alu_acc_seq #(.WIDTH(8), .ACC_SAT(1'b1)) dut_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
      .opcode(opcode), .A(A), .B(B), .acc_clr(acc_clr),
      .out_valid(s_out_valid), .out_ready(out_ready), .res(s_res),
      .carry(s_carry), .zero(s_zero), .err(s_err)
   );

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Issue one op, wait (bounded) for out_valid, check latency, busy cycles,
   // result and flags, then retire it with a one-cycle out_ready.
   task automatic run_op(input string tag, input logic [3:0] op,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic clr, input int exp_lat,
                         input int e_res, input int e_c, input int e_z,
                         input int e_e);
      int lat;
      int busy;
      @(negedge clk);
      check({tag, ".in_ready"}, int'(in_ready), 1);
      opcode = op; A = a; B = b; acc_clr = clr; in_valid = 1'b1;
      @(negedge clk);
      // operands must already be captured; disturb them
      in_valid = 1'b0; acc_clr = 1'b0; A = ~a; B = 8'd0; opcode = 4'd12;
      lat = 1;
      busy = 0;
      while (!out_valid && lat < 40) begin
         if (!in_ready) busy++;
         @(negedge clk);
         lat++;
      end
      check({tag, ".latency"}, lat, exp_lat);
      check({tag, ".busy"}, busy, exp_lat - 1);
      check({tag, ".res"}, int'(res), e_res);
      check({tag, ".carry"}, int'(carry), e_c);
      check({tag, ".zero"}, int'(zero), e_z);
      check({tag, ".err"}, int'(err), e_e);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, ".retired"}, int'(out_valid), 0);
   endtask

   initial begin
      // reset state
      repeat (2) @(negedge clk);
      check("rst.in_ready", int'(in_ready), 1);
      check("rst.out_valid", int'(out_valid), 0);
      check("rst.res", int'(res), 0);
      check("rst.flags", int'({carry, zero, err}), 0);
      rst_n = 1'b1;

      run_op("add", 4'd0, 8'd200, 8'd100, 1'b0, 1, 44, 1, 0, 0);
      run_op("div", 4'd3, 8'd200, 8'd7, 1'b0, 9, 28, 0, 0, 0);
      run_op("div0", 4'd3, 8'd5, 8'd0, 1'b0, 1, 255, 0, 0, 1);

      run_op("mac1", 4'd6, 8'd3, 8'd4, 1'b1, 1, 12, 0, 0, 0);
      check("mac1.sat_res", int'(s_res), 12);
      run_op("mac2", 4'd6, 8'd5, 8'd6, 1'b0, 1, 42, 0, 0, 0);
      check("mac2.sat_res", int'(s_res), 42);
      run_op("adda", 4'd4, 8'd250, 8'd0, 1'b0, 1, 36, 1, 0, 0);
      check("adda.sat_res", int'(s_res), 255);
      check("adda.sat_carry", int'(s_carry), 1);

      run_op("rol", 4'd7, 8'h81, 8'd1, 1'b0, 1, 8'h03, 0, 0, 0);
      run_op("ror", 4'd8, 8'h81, 8'd4, 1'b0, 1, 8'h18, 0, 0, 0);
      run_op("gth", 4'd14, 8'd9, 8'd3, 1'b0, 1, 1, 0, 0, 0);
      run_op("lth", 4'd15, 8'd9, 8'd3, 1'b0, 1, 0, 0, 1, 0);
      run_op("sub", 4'd1, 8'd3, 8'd5, 1'b0, 1, 254, 1, 0, 0);
      run_op("mul", 4'd2, 8'd20, 8'd20, 1'b0, 1, 144, 1, 0, 0);
      run_op("nand", 4'd12, 8'hF0, 8'hFF, 1'b0, 1, 8'h0F, 0, 0, 0);
      run_op("xor", 4'd11, 8'hAA, 8'hAA, 1'b0, 1, 0, 0, 1, 0);
      run_op("eth", 4'd13, 8'd7, 8'd7, 1'b0, 1, 1, 0, 0, 0);

      // acc_clr in IDLE without an accept: acc cleared, res untouched
      @(negedge clk);
      acc_clr = 1'b1;
      @(negedge clk);
      acc_clr = 1'b0;
      check("clr.out_valid", int'(out_valid), 0);
      check("clr.res", int'(res), 1);
      run_op("adda5", 4'd4, 8'd5, 8'd0, 1'b0, 1, 5, 0, 0, 0);
      run_op("mula3", 4'd5, 8'd3, 8'd0, 1'b0, 1, 15, 0, 0, 0);
      run_op("mula20", 4'd5, 8'd20, 8'd0, 1'b0, 1, 44, 1, 0, 0);

      // HOLD stall with out_ready low and a competing in_valid
      @(negedge clk);
      opcode = 4'd0; A = 8'd1; B = 8'd2; in_valid = 1'b1;
      @(negedge clk);
      check("stall.valid", int'(out_valid), 1);
      for (int i = 0; i < 3; i++) begin
         opcode = 4'd1; A = 8'd50; B = 8'd9; in_valid = 1'b1;
         @(negedge clk);
         check("stall.res", int'(res), 3);
         check("stall.hold", int'({out_valid, in_ready, carry, zero, err}), 5'b10000);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("stall.release", int'({out_valid, in_ready}), 2'b01);
      check("stall.res_kept", int'(res), 3);
      run_op("after_stall", 4'd0, 8'd4, 8'd4, 1'b0, 1, 8, 0, 0, 0);

      // asynchronous reset in the middle of a divide
      @(negedge clk);
      opcode = 4'd3; A = 8'd200; B = 8'd7; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("mid.busy", int'(in_ready), 0);
      #2 rst_n = 1'b0;
      #1;
      check("mid.rst_out_valid", int'(out_valid), 0);
      check("mid.rst_in_ready", int'(in_ready), 1);
      check("mid.rst_res", int'(res), 0);
      check("mid.rst_flags", int'({carry, zero, err}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid) check("mid.stale_valid", int'(out_valid), 0);
      end
      check("mid.idle", int'({out_valid, in_ready}), 2'b01);
      run_op("post_rst", 4'd0, 8'd1, 8'd1, 1'b0, 1, 2, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
